soc_rom_arbiter: RTL and testbench

Sequencer and two-port arbiter for the SoC boot ROM. It shares the combinational `soc_rom` lookup between the instruction-fetch Wishbone master (m0) and the data Wishbone master (m1). It grants them round-robin, registers the ROM address and data, and returns classic-Wishbone ack/err with fixed latency. It sits between the core's two bus ports and the ROM window at the top of the address space.

---
 rtl/soc_rom_arbiter_pkg.sv | 18 +
 rtl/soc_rom_arbiter_resp.sv | 47 ++++
 rtl/soc_rom_arbiter.sv | 125 ++++++++++++
 tb/tb_soc_rom_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_rom_arbiter_pkg.sv
// soc_rom_arbiter_pkg
//   Shared widths and FSM state encoding for the boot-ROM arbiter.
//   WB_ADDR_W : Wishbone word-address width
//   RW        : ROM data word width
//   arb_state_e : arbiter sequencer states
package soc_rom_arbiter_pkg;

  localparam int WB_ADDR_W = 24;
  localparam int RW        = 16;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_READ = 2'd1,
    ARB_ACK  = 2'd2,
    ARB_ERR  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/soc_rom_arbiter_resp.sv
// soc_rom_arbiter_resp
//   Per-master Wishbone response register: one-cycle ack/err pulses and a
//   read-data register that only changes when an ack is being raised.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   ack_set_i    : raise ack next cycle and capture data_i
//   err_set_i    : raise err next cycle, data untouched
//   data_i       : ROM data to capture
//   ack_o, err_o : registered completion strobes
//   dat_o        : last data returned to this master
module soc_rom_arbiter_resp
  import soc_rom_arbiter_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          ack_set_i,
  input  logic          err_set_i,
  input  logic [RW-1:0] data_i,
  output logic          ack_o,
  output logic          err_o,
  output logic [RW-1:0] dat_o
);

  logic          ack_q;
  logic          err_q;
  logic [RW-1:0] dat_q;

  // The set inputs are single-cycle by construction of the sequencer, so
  // following them directly yields one-cycle strobes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= ack_set_i;
      err_q <= err_set_i;
      if (ack_set_i) begin
        dat_q <= data_i;
      end
    end
  end

  assign ack_o = ack_q;
  assign err_o = err_q;
  assign dat_o = dat_q;

endmodule

// File: rtl/soc_rom_arbiter.sv
// soc_rom_arbiter
//   Round-robin sequencer sharing the combinational boot ROM between the
//   instruction-fetch master (m0) and the data master (m1). Reads complete
//   with a fixed 2-cycle ack latency, writes and out-of-window accesses get
//   a 1-cycle err.
//   i_clk, i_rst        : clock, asynchronous active-high reset
//   mK_wb_cyc/stb/we/adr: master K request
//   mK_wb_ack/err/i_dat : master K response
//   rom_addr, rom_data  : link to the external soc_rom lookup
module soc_rom_arbiter
  import soc_rom_arbiter_pkg::*;
#(
  parameter logic [WB_ADDR_W-1:0] ROM_BASE = 24'hffe000,
  parameter int                   ROM_AW   = 13
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 m0_wb_cyc,
  input  logic                 m0_wb_stb,
  input  logic                 m0_wb_we,
  input  logic [WB_ADDR_W-1:0] m0_wb_adr,
  output logic                 m0_wb_ack,
  output logic                 m0_wb_err,
  output logic [RW-1:0]        m0_wb_i_dat,
  input  logic                 m1_wb_cyc,
  input  logic                 m1_wb_stb,
  input  logic                 m1_wb_we,
  input  logic [WB_ADDR_W-1:0] m1_wb_adr,
  output logic                 m1_wb_ack,
  output logic                 m1_wb_err,
  output logic [RW-1:0]        m1_wb_i_dat,
  output logic [WB_ADDR_W-1:0] rom_addr,
  input  logic [RW-1:0]        rom_data
);

  arb_state_e           state_q;
  logic                 gnt_q;
  logic                 prio_q;
  logic [WB_ADDR_W-1:0] rom_addr_q;

  logic                 req0;
  logic                 req1;
  logic                 any_req;
  logic                 win;
  logic [WB_ADDR_W-1:0] win_adr;
  logic                 win_ok;
  logic                 gnt_cyc;
  logic                 ack_set;
  logic                 err_set;

  assign req0    = m0_wb_cyc & m0_wb_stb;
  assign req1    = m1_wb_cyc & m1_wb_stb;
  assign any_req = req0 | req1;

  // Contention is settled by prio; otherwise the lone requester wins
  // (win=1 selects m1).
  assign win     = (req0 & req1) ? prio_q : req1;
  assign win_adr = win ? m1_wb_adr : m0_wb_adr;
  assign win_ok  = !(win ? m1_wb_we : m0_wb_we) &&
                   (win_adr[WB_ADDR_W-1:ROM_AW] == ROM_BASE[WB_ADDR_W-1:ROM_AW]);

  assign gnt_cyc = gnt_q ? m1_wb_cyc : m0_wb_cyc;

  // A read is acked only if the granted master is still in its cycle;
  // dropping cyc during READ aborts silently.
  assign ack_set = (state_q == ARB_READ) && gnt_cyc;
  assign err_set = (state_q == ARB_IDLE) && any_req && !win_ok;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ARB_IDLE;
      gnt_q      <= 1'b0;
      prio_q     <= 1'b0;
      rom_addr_q <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (any_req) begin
            gnt_q <= win;
            if (win_ok) begin
              rom_addr_q <= win_adr;
              state_q    <= ARB_READ;
            end else begin
              state_q <= ARB_ERR;
            end
          end
        end
        ARB_READ: begin
          state_q <= gnt_cyc ? ARB_ACK : ARB_IDLE;
        end
        // Only completed transfers rotate priority; an abort leaves it alone.
        ARB_ACK, ARB_ERR: begin
          prio_q  <= ~gnt_q;
          state_q <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign rom_addr = rom_addr_q;

  soc_rom_arbiter_resp u_resp0 (
    .clk_i     (i_clk),
    .rst_i     (i_rst),
    .ack_set_i (ack_set & ~gnt_q),
    .err_set_i (err_set & ~win),
    .data_i    (rom_data),
    .ack_o     (m0_wb_ack),
    .err_o     (m0_wb_err),
    .dat_o     (m0_wb_i_dat)
  );

  soc_rom_arbiter_resp u_resp1 (
    .clk_i     (i_clk),
    .rst_i     (i_rst),
    .ack_set_i (ack_set & gnt_q),
    .err_set_i (err_set & win),
    .data_i    (rom_data),
    .ack_o     (m1_wb_ack),
    .err_o     (m1_wb_err),
    .dat_o     (m1_wb_i_dat)
  );

endmodule

// File: tb/tb_soc_rom_arbiter.sv
// tb_soc_rom_arbiter
//   Directed bench for the boot-ROM arbiter. Inputs are driven and outputs
//   sampled on the falling clock edge; the DUT acts on the rising edge.
//   Every check compares a snapshot of all response outputs plus rom_addr
//   against a hand-computed value.
module tb_soc_rom_arbiter;
  import soc_rom_arbiter_pkg::*;

  logic                 i_clk = 1'b0;
  logic                 i_rst;
  logic                 m0_wb_cyc, m0_wb_stb, m0_wb_we;
  logic [WB_ADDR_W-1:0] m0_wb_adr;
  logic                 m0_wb_ack, m0_wb_err;
  logic [RW-1:0]        m0_wb_i_dat;
  logic                 m1_wb_cyc, m1_wb_stb, m1_wb_we;
  logic [WB_ADDR_W-1:0] m1_wb_adr;
  logic                 m1_wb_ack, m1_wb_err;
  logic [RW-1:0]        m1_wb_i_dat;
  logic [WB_ADDR_W-1:0] rom_addr;
  logic [RW-1:0]        rom_data;

  int checks = 0;
  int errors = 0;

  logic [59:0] obs;

  soc_rom_arbiter dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .m0_wb_cyc   (m0_wb_cyc),
    .m0_wb_stb   (m0_wb_stb),
    .m0_wb_we    (m0_wb_we),
    .m0_wb_adr   (m0_wb_adr),
    .m0_wb_ack   (m0_wb_ack),
    .m0_wb_err   (m0_wb_err),
    .m0_wb_i_dat (m0_wb_i_dat),
    .m1_wb_cyc   (m1_wb_cyc),
    .m1_wb_stb   (m1_wb_stb),
    .m1_wb_we    (m1_wb_we),
    .m1_wb_adr   (m1_wb_adr),
    .m1_wb_ack   (m1_wb_ack),
    .m1_wb_err   (m1_wb_err),
    .m1_wb_i_dat (m1_wb_i_dat),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data)
  );

  always #5 i_clk = ~i_clk;

  // Small stand-in for soc_rom: only the words the scenarios touch.
  always_comb begin
    rom_data = 16'hdead;
    case (rom_addr)
      24'hffe002: rom_data = 16'h0004;
      24'hffe004: rom_data = 16'h0005;
      24'hffe00a: rom_data = 16'h00aa;
      24'hffe00c: rom_data = 16'h000e;
      24'hffe00d: rom_data = 16'h0002;
      default:    rom_data = 16'hdead;
    endcase
  end

  assign obs = {m0_wb_ack, m0_wb_err, m0_wb_i_dat,
                m1_wb_ack, m1_wb_err, m1_wb_i_dat, rom_addr};

  function automatic logic [59:0] mk(input logic a0, input logic e0, input logic [15:0] d0,
                                     input logic a1, input logic e1, input logic [15:0] d1,
                                     input logic [23:0] ra);
    return {a0, e0, d0, a1, e1, d1, ra};
  endfunction

  // Drive one master: req sets both cyc and stb.
  task automatic applyStimulus(input int m, input logic req, input logic we,
                               input logic [23:0] adr);
    if (m == 0) begin
      m0_wb_cyc = req; m0_wb_stb = req; m0_wb_we = we; m0_wb_adr = adr;
    end else begin
      m1_wb_cyc = req; m1_wb_stb = req; m1_wb_we = we; m1_wb_adr = adr;
    end
  endtask

  task automatic test_reset();
    logic [59:0] exp;
    i_rst = 1'b1;
    applyStimulus(0, 1'b0, 1'b0, 24'h0);
    applyStimulus(1, 1'b0, 1'b0, 24'h0);
    @(negedge i_clk);
    exp = mk(0, 0, 16'h0, 0, 0, 16'h0, 24'h0); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL reset_held got %h want %h", obs, exp); end
    i_rst = 1'b0;
    @(negedge i_clk);
    exp = mk(0, 0, 16'h0, 0, 0, 16'h0, 24'h0); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL reset_released got %h want %h", obs, exp); end
  endtask

  task automatic test_simultaneous();
    logic [59:0] exp;
    @(negedge i_clk);
    applyStimulus(0, 1'b1, 1'b0, 24'hffe002);
    applyStimulus(1, 1'b1, 1'b0, 24'hffe00c);
    @(negedge i_clk);
    exp = mk(0, 0, 16'h0, 0, 0, 16'h0, 24'hffe002); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL simul_n1 got %h want %h", obs, exp); end
    @(negedge i_clk);
    exp = mk(1, 0, 16'h0004, 0, 0, 16'h0, 24'hffe002); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL simul_m0_ack got %h want %h", obs, exp); end
    applyStimulus(0, 1'b0, 1'b0, 24'h0);
    @(negedge i_clk);
    exp = mk(0, 0, 16'h0004, 0, 0, 16'h0, 24'hffe002); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL simul_n3 got %h want %h", obs, exp); end
    @(negedge i_clk);
    exp = mk(0, 0, 16'h0004, 0, 0, 16'h0, 24'hffe00c); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL simul_n4 got %h want %h", obs, exp); end
    @(negedge i_clk);
    exp = mk(0, 0, 16'h0004, 1, 0, 16'h000e, 24'hffe00c); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL simul_m1_ack got %h want %h", obs, exp); end
    applyStimulus(1, 1'b0, 1'b0, 24'h0);
    @(negedge i_clk);
    exp = mk(0, 0, 16'h0004, 0, 0, 16'h000e, 24'hffe00c); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL simul_n6 got %h want %h", obs, exp); end
    // Second contention: priority has rotated back to m0.
    applyStimulus(0, 1'b1, 1'b0, 24'hffe00d);
    applyStimulus(1, 1'b1, 1'b0, 24'hffe004);
    @(negedge i_clk);
    exp = mk(0, 0, 16'h0004, 0, 0, 16'h000e, 24'hffe00d); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL simul_again_addr got %h want %h", obs, exp); end
    @(negedge i_clk);
    exp = mk(1, 0, 16'h0002, 0, 0, 16'h000e, 24'hffe00d); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL simul_again_ack got %h want %h", obs, exp); end
    applyStimulus(0, 1'b0, 1'b0, 24'h0);
    applyStimulus(1, 1'b0, 1'b0, 24'h0);
    @(negedge i_clk);
    exp = mk(0, 0, 16'h0002, 0, 0, 16'h000e, 24'hffe00d); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL simul_end got %h want %h", obs, exp); end
  endtask

  task automatic test_single_read();
    logic [59:0] exp;
    applyStimulus(0, 1'b1, 1'b0, 24'hffe004);
    @(negedge i_clk);
    exp = mk(0, 0, 16'h0002, 0, 0, 16'h000e, 24'hffe004); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL single_n1 got %h want %h", obs, exp); end
    @(negedge i_clk);
    exp = mk(1, 0, 16'h0005, 0, 0, 16'h000e, 24'hffe004); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL single_ack got %h want %h", obs, exp); end
    applyStimulus(0, 1'b0, 1'b0, 24'h0);
    @(negedge i_clk);
    exp = mk(0, 0, 16'h0005, 0, 0, 16'h000e, 24'hffe004); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL single_n3 got %h want %h", obs, exp); end
  endtask

  task automatic test_write_err();
    logic [59:0] exp;
    applyStimulus(1, 1'b1, 1'b1, 24'hffe000);
    @(negedge i_clk);
    exp = mk(0, 0, 16'h0005, 0, 1, 16'h000e, 24'hffe004); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL write_err got %h want %h", obs, exp); end
    applyStimulus(1, 1'b0, 1'b0, 24'h0);
    @(negedge i_clk);
    exp = mk(0, 0, 16'h0005, 0, 0, 16'h000e, 24'hffe004); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL write_err_end got %h want %h", obs, exp); end
  endtask

  task automatic test_out_of_window();
    logic [59:0] exp;
    applyStimulus(0, 1'b1, 1'b0, 24'h001000);
    @(negedge i_clk);
    exp = mk(0, 1, 16'h0005, 0, 0, 16'h000e, 24'hffe004); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL oow_err got %h want %h", obs, exp); end
    applyStimulus(0, 1'b0, 1'b0, 24'h0);
    @(negedge i_clk);
    exp = mk(0, 0, 16'h0005, 0, 0, 16'h000e, 24'hffe004); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL oow_end got %h want %h", obs, exp); end
    // One word below the window base.
    applyStimulus(1, 1'b1, 1'b0, 24'hffdfff);
    @(negedge i_clk);
    exp = mk(0, 0, 16'h0005, 0, 1, 16'h000e, 24'hffe004); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL below_base_err got %h want %h", obs, exp); end
    applyStimulus(1, 1'b0, 1'b0, 24'h0);
    @(negedge i_clk);
    // Last word of the window is a valid read.
    applyStimulus(1, 1'b1, 1'b0, 24'hffffff);
    @(negedge i_clk);
    exp = mk(0, 0, 16'h0005, 0, 0, 16'h000e, 24'hffffff); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL top_word_addr got %h want %h", obs, exp); end
    @(negedge i_clk);
    exp = mk(0, 0, 16'h0005, 1, 0, 16'hdead, 24'hffffff); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL top_word_ack got %h want %h", obs, exp); end
    applyStimulus(1, 1'b0, 1'b0, 24'h0);
    @(negedge i_clk);
  endtask

  task automatic test_abort();
    logic [59:0] exp;
    applyStimulus(1, 1'b1, 1'b0, 24'hffe00a);
    @(negedge i_clk);
    exp = mk(0, 0, 16'h0005, 0, 0, 16'hdead, 24'hffe00a); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL abort_n1 got %h want %h", obs, exp); end
    applyStimulus(1, 1'b0, 1'b0, 24'h0);
    applyStimulus(0, 1'b1, 1'b0, 24'hffe00d);
    @(negedge i_clk);
    exp = mk(0, 0, 16'h0005, 0, 0, 16'hdead, 24'hffe00a); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL abort_no_ack got %h want %h", obs, exp); end
    @(negedge i_clk);
    exp = mk(0, 0, 16'h0005, 0, 0, 16'hdead, 24'hffe00d); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL abort_m0_addr got %h want %h", obs, exp); end
    @(negedge i_clk);
    exp = mk(1, 0, 16'h0002, 0, 0, 16'hdead, 24'hffe00d); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL abort_m0_ack got %h want %h", obs, exp); end
    applyStimulus(0, 1'b0, 1'b0, 24'h0);
    @(negedge i_clk);
    exp = mk(0, 0, 16'h0002, 0, 0, 16'hdead, 24'hffe00d); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL abort_end got %h want %h", obs, exp); end
  endtask

  task automatic test_reset_mid_read();
    logic [59:0] exp;
    applyStimulus(0, 1'b1, 1'b0, 24'hffe004);
    @(negedge i_clk);
    exp = mk(0, 0, 16'h0002, 0, 0, 16'hdead, 24'hffe004); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL rst_mid_n1 got %h want %h", obs, exp); end
    #1 i_rst = 1'b1;
    applyStimulus(0, 1'b0, 1'b0, 24'h0);
    #1;
    exp = mk(0, 0, 16'h0, 0, 0, 16'h0, 24'h0); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL rst_mid_async got %h want %h", obs, exp); end
    @(negedge i_clk);
    exp = mk(0, 0, 16'h0, 0, 0, 16'h0, 24'h0); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL rst_mid_held got %h want %h", obs, exp); end
    i_rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge i_clk);
      exp = mk(0, 0, 16'h0, 0, 0, 16'h0, 24'h0); checks++;
      if (obs !== exp) begin errors++; $display("[TB] FAIL rst_mid_no_ack%0d got %h want %h", i, obs, exp); end
    end
    // Fresh contention after reset goes to m0 first.
    applyStimulus(0, 1'b1, 1'b0, 24'hffe00c);
    applyStimulus(1, 1'b1, 1'b0, 24'hffe002);
    @(negedge i_clk);
    exp = mk(0, 0, 16'h0, 0, 0, 16'h0, 24'hffe00c); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL post_rst_addr got %h want %h", obs, exp); end
    @(negedge i_clk);
    exp = mk(1, 0, 16'h000e, 0, 0, 16'h0, 24'hffe00c); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL post_rst_m0_ack got %h want %h", obs, exp); end
    applyStimulus(0, 1'b0, 1'b0, 24'h0);
    @(negedge i_clk);
    @(negedge i_clk);
    exp = mk(0, 0, 16'h000e, 0, 0, 16'h0, 24'hffe002); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL post_rst_m1_addr got %h want %h", obs, exp); end
    @(negedge i_clk);
    exp = mk(0, 0, 16'h000e, 1, 0, 16'h0004, 24'hffe002); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL post_rst_m1_ack got %h want %h", obs, exp); end
    applyStimulus(1, 1'b0, 1'b0, 24'h0);
    @(negedge i_clk);
    exp = mk(0, 0, 16'h000e, 0, 0, 16'h0004, 24'hffe002); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL post_rst_end got %h want %h", obs, exp); end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_simultaneous();
    test_single_read();
    test_write_err();
    test_out_of_window();
    test_abort();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
